fse_pipe: RTL and testbench
===========================

# fse_pipe

Parametrised, pipelined successor of the complex fractionally-spaced equalizer.
It runs a complex FIR of generic length over T/2-spaced I/Q samples and decimates to the symbol rate by a parametric factor.
Coefficients are loaded one tap at a time into a shadow bank and made active atomically on commit. Outputs are rounded or truncated, then saturated to S(NBT_OUT,NBF_OUT), with a sticky saturation flag.
The block sits between the matched filter / downsampler and the slicer/LMS tap-update logic.

## Interface
- NUM_TAPS, 9: filter length, ≥2; the adder tree is generated, with no fixed tap count.
- NBT_IN / NBF_IN, 8 / 7: input sample format S(8,7).
- NBT_TAPS / NBF_TAPS, 28 / 25: tap format S(28,25).
- NBT_OUT / NBF_OUT, 12 / 9: output format S(12,9). Requires NBF_IN+NBF_TAPS > NBF_OUT.
- DECIM, 2: output decimation factor, 1 or 2.
- clk  input  1  single clock; all state updates on rising edge.
- i_reset  input  1  reset, asynchronous and active-low (0 = reset).
- i_is_data_I / i_is_data_Q  input  NBT_IN  signed sample.
- i_is_valid  input  1  sample strobe; shifts the delay line.
- i_tap_wr  input  1  write i_tap_I/i_tap_Q into shadow[i_tap_addr].
- i_tap_addr  input  $clog2(NUM_TAPS)  shadow tap index.
- i_tap_I / i_tap_Q  input  NBT_TAPS  signed tap value.
- i_tap_commit  input  1  copy the shadow bank to the active bank.
- i_round  input  1  1 = round half-up, 0 = truncate (floor).
- i_sat_clr  input  1  clear o_sat.
- o_os_data_I / o_os_data_Q  output  NBT_OUT  signed equalized sample.
- o_os_valid  output  1  one-cycle strobe marking a new output.
- o_sat  output  1  sticky: an output was saturated since the last clear.

## Operation
- Reset state:
  - Delay line cleared to 0.
  - Active and shadow banks: I[NUM_TAPS/2] = 1.0 (1<<NBF_TAPS); all other taps 0; all Q taps 0.
  - Pipeline registers, o_os_data_I/Q, o_os_valid, o_sat and the phase counter all 0.
  - Reset asserted mid-stream clears everything immediately (asynchronously); in-flight samples are discarded.
- Delay line: on i_is_valid, shift[0] ← input and shift[k] ← shift[k-1]; otherwise it holds.
- Tap bank:
  - i_tap_wr writes the shadow bank; writes with i_tap_addr ≥ NUM_TAPS are ignored.
  - i_tap_commit copies all shadow taps to the active bank in one cycle.
  - On simultaneous write and commit, the committed bank includes that write.
- Arithmetic:
  - Products: pII = sI·tI, pQQ = sQ·tQ, pIQ = sI·tQ, pQI = sQ·tI, each NBT_IN+NBT_TAPS bits.
  - Each product sum is widened by $clog2(NUM_TAPS) bits.
  - Combine: yI = ΣpII − ΣpQQ and yQ = ΣpIQ + ΣpQI, each one further bit wide. No intermediate wrap is allowed.
  - Quantisation: drop D = NBF_IN+NBF_TAPS−NBF_OUT LSBs. With i_round=1, add 1<<(D−1) first, in one extra guard bit.
  - Saturation: clamp to [−2^(NBT_OUT−1), 2^(NBT_OUT−1)−1].
- Decimation:
  - A phase counter (0..DECIM−1) advances on each i_is_valid.
  - A sample is "output-bearing" when the counter equals DECIM−1 at its acceptance. With DECIM=1, every sample is output-bearing.
- Saturation flag: o_sat is set on any o_os_valid cycle whose I or Q value clamped. Set has priority over i_sat_clr in the same cycle.

## Timing
- Pipeline:
  - Sample accepted in cycle n: delay line updated at the end of n.
  - Products registered at the end of n+1.
  - The three sums registered at the end of n+2.
  - Combine/round/saturate registered at the end of n+3.
  - Output visible in cycle n+4 with o_os_valid=1 for one cycle.
- Latency: 4 cycles. Throughput: one sample per cycle. Back-to-back i_is_valid is supported.
- o_os_data_I/Q hold their value between valid strobes.
- Taps take effect on the product stage: a commit at the end of cycle c applies to products registered at the end of c+1 onward.
- A commit never mixes old and new taps within one output.
- i_is_valid=0 stalls nothing; pipeline stages keep advancing and only the valid bits gate the output.

## Test plan
- Identity impulse, DECIM=1, reset taps: I=64 (0.5), then zeros, continuous valid.
  - Required: the 5th output has I=256, Q=0; all other outputs are 0.
  - First o_os_valid comes exactly 4 cycles after the first strobe.
- Complex rotation: write I[4]=0, Q[4]=1<<25, then commit.
  - Input (I=64, Q=0) → output (0, 256).
  - Input (0, 64) → output (−256, 0).
- Saturation: taps I[3]=I[4]=3<<25, two consecutive inputs I=127.
  - Required: output 2047 and o_sat=1.
  - Repeat with −128 inputs → −2048.
  - i_sat_clr asserted in the same cycle as a new saturation leaves o_sat=1.
- Rounding: tap I[4]=1<<22 (0.125), input ±1.
  - i_round=0 → +1 gives 0, −1 gives −1.
  - i_round=1 → +1 gives 1, −1 gives 0.
- Shadow/commit:
  - Write all shadow taps mid-stream without commit → outputs unchanged.
  - Commit in cycle c → outputs switch cleanly to the new response, with no mixed-bank output.
  - A write to addr 9 has no effect.
- Reset and decimation:
  - DECIM=2: o_os_valid on every 2nd strobe, phase starting from reset.
  - Drop i_reset mid-stream → all outputs 0 immediately, taps back to identity.

Source files
------------

// File: rtl/fse_pipe.sv
// Pipelined complex fractionally-spaced equalizer with decimating output.
// Complex FIR over T/2-spaced I/Q samples, shadow/active tap banks with atomic
// commit, round-or-truncate quantisation and saturation with a sticky flag.
// Pipeline: delay line -> products -> sums -> combine/quantise/saturate.
module fse_pipe #(
  parameter int NUM_TAPS = 9,
  parameter int NBT_IN   = 8,
  parameter int NBF_IN   = 7,
  parameter int NBT_TAPS = 28,
  parameter int NBF_TAPS = 25,
  parameter int NBT_OUT  = 12,
  parameter int NBF_OUT  = 9,
  parameter int DECIM    = 2,
  localparam int AW      = $clog2(NUM_TAPS)
) (
  input  logic                       clk,
  input  logic                       i_reset,
  input  logic signed [NBT_IN-1:0]   i_is_data_I,
  input  logic signed [NBT_IN-1:0]   i_is_data_Q,
  input  logic                       i_is_valid,
  input  logic                       i_tap_wr,
  input  logic [AW-1:0]              i_tap_addr,
  input  logic signed [NBT_TAPS-1:0] i_tap_I,
  input  logic signed [NBT_TAPS-1:0] i_tap_Q,
  input  logic                       i_tap_commit,
  input  logic                       i_round,
  input  logic                       i_sat_clr,
  output logic signed [NBT_OUT-1:0]  o_os_data_I,
  output logic signed [NBT_OUT-1:0]  o_os_data_Q,
  output logic                       o_os_valid,
  output logic                       o_sat
);

  localparam int PW  = NBT_IN + NBT_TAPS;        // product width
  localparam int SW  = PW + $clog2(NUM_TAPS);    // per-product-type sum width
  localparam int CW  = SW + 1;                   // combined I/Q width
  localparam int RW  = CW + 1;                   // guard bit for rounding
  localparam int D   = NBF_IN + NBF_TAPS - NBF_OUT;
  localparam int CTR = NUM_TAPS / 2;
  localparam int PHW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic signed [NBT_TAPS-1:0] TAP_ONE = NBT_TAPS'(64'sd1 << NBF_TAPS);
  localparam logic signed [RW-1:0] RND     = RW'(64'sd1 << (D - 1));
  localparam logic signed [RW-1:0] SAT_MAX = RW'((64'sd1 << (NBT_OUT - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = RW'(-(64'sd1 << (NBT_OUT - 1)));

  logic signed [NBT_IN-1:0]   dl_i  [NUM_TAPS];
  logic signed [NBT_IN-1:0]   dl_q  [NUM_TAPS];
  logic signed [NBT_TAPS-1:0] sh_i  [NUM_TAPS];
  logic signed [NBT_TAPS-1:0] sh_q  [NUM_TAPS];
  logic signed [NBT_TAPS-1:0] act_i [NUM_TAPS];
  logic signed [NBT_TAPS-1:0] act_q [NUM_TAPS];
  logic signed [PW-1:0]       p_ii  [NUM_TAPS];
  logic signed [PW-1:0]       p_qq  [NUM_TAPS];
  logic signed [PW-1:0]       p_iq  [NUM_TAPS];
  logic signed [PW-1:0]       p_qi  [NUM_TAPS];

  logic [PHW-1:0]       phase;
  logic                 bearing;
  logic                 v0, v1, v2;
  logic signed [SW-1:0] sum_ii_c, sum_qq_c, s_ii, s_qq;
  logic signed [CW-1:0] sum_x_c, s_x;
  logic signed [CW-1:0] y_i_c, y_q_c;
  logic [NBT_OUT:0]     q_i_c, q_q_c;

  // Returns {clamped, value}: optional half-up rounding, floor shift, clamp.
  function automatic logic [NBT_OUT:0] quantise(input logic signed [CW-1:0] y,
                                                input logic rnd);
    logic signed [RW-1:0] t;
    t = RW'(y);
    if (rnd) t = t + RND;
    t = t >>> D;
    if (t > SAT_MAX) return {2'b10, {(NBT_OUT-1){1'b1}}};
    if (t < SAT_MIN) return {2'b11, {(NBT_OUT-1){1'b0}}};
    return {1'b0, t[NBT_OUT-1:0]};
  endfunction

  assign bearing = (phase == PHW'(DECIM - 1));

  // Sample delay line: shifts only on an accepted sample.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        dl_i[k] <= '0;
        dl_q[k] <= '0;
      end
    end else if (i_is_valid) begin
      dl_i[0] <= i_is_data_I;
      dl_q[0] <= i_is_data_Q;
      for (int k = 1; k < NUM_TAPS; k++) begin
        dl_i[k] <= dl_i[k-1];
        dl_q[k] <= dl_q[k-1];
      end
    end
  end

  // Decimation phase; v0 marks an output-bearing sample entering the pipe.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      phase <= '0;
      v0    <= 1'b0;
    end else begin
      v0 <= i_is_valid & bearing;
      if (i_is_valid) phase <= bearing ? '0 : phase + 1'b1;
    end
  end

  // Shadow/active tap banks; a same-cycle write is folded into the commit.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        sh_i[k]  <= (k == CTR) ? TAP_ONE : '0;
        act_i[k] <= (k == CTR) ? TAP_ONE : '0;
        sh_q[k]  <= '0;
        act_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        if (i_tap_wr && i_tap_addr == AW'(k)) begin
          sh_i[k] <= i_tap_I;
          sh_q[k] <= i_tap_Q;
        end
        if (i_tap_commit) begin
          act_i[k] <= (i_tap_wr && i_tap_addr == AW'(k)) ? i_tap_I : sh_i[k];
          act_q[k] <= (i_tap_wr && i_tap_addr == AW'(k)) ? i_tap_Q : sh_q[k];
        end
      end
    end
  end

  // Product stage: every product of one output sees the same active bank.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        p_ii[k] <= '0;
        p_qq[k] <= '0;
        p_iq[k] <= '0;
        p_qi[k] <= '0;
      end
      v1 <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        p_ii[k] <= PW'(dl_i[k]) * PW'(act_i[k]);
        p_qq[k] <= PW'(dl_q[k]) * PW'(act_q[k]);
        p_iq[k] <= PW'(dl_i[k]) * PW'(act_q[k]);
        p_qi[k] <= PW'(dl_q[k]) * PW'(act_i[k]);
      end
      v1 <= v0;
    end
  end

  // Full-width accumulation of the products; cross terms share one sum.
  always_comb begin
    sum_ii_c = '0;
    sum_qq_c = '0;
    sum_x_c  = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      sum_ii_c = sum_ii_c + SW'(p_ii[k]);
      sum_qq_c = sum_qq_c + SW'(p_qq[k]);
      sum_x_c  = sum_x_c + CW'(p_iq[k]) + CW'(p_qi[k]);
    end
  end

  // Sum stage register.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      s_ii <= '0;
      s_qq <= '0;
      s_x  <= '0;
      v2   <= 1'b0;
    end else begin
      s_ii <= sum_ii_c;
      s_qq <= sum_qq_c;
      s_x  <= sum_x_c;
      v2   <= v1;
    end
  end

  // Complex combine followed by quantisation of each rail.
  always_comb begin
    y_i_c = CW'(s_ii) - CW'(s_qq);
    y_q_c = s_x;
    q_i_c = quantise(y_i_c, i_round);
    q_q_c = quantise(y_q_c, i_round);
  end

  // Output register; data holds between strobes, saturation set beats clear.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      o_os_data_I <= '0;
      o_os_data_Q <= '0;
      o_os_valid  <= 1'b0;
      o_sat       <= 1'b0;
    end else begin
      o_os_valid <= v2;
      if (v2) begin
        o_os_data_I <= q_i_c[NBT_OUT-1:0];
        o_os_data_Q <= q_q_c[NBT_OUT-1:0];
      end
      o_sat <= (v2 & (q_i_c[NBT_OUT] | q_q_c[NBT_OUT])) | (o_sat & ~i_sat_clr);
    end
  end

endmodule

// File: tb/tb_fse_pipe.sv
// Bench for fse_pipe: two instances (DECIM=1 and DECIM=2) share all inputs and
// are compared every cycle against an arithmetic model of the filter.
module tb_fse_pipe;

  localparam int NT   = 9;
  localparam int D    = 7 + 25 - 9;
  localparam int OMAX = 2047;
  localparam int OMIN = -2048;

  logic clk = 1'b0;
  logic i_reset = 1'b0;
  logic signed [7:0]  s_i = '0, s_q = '0;
  logic               valid = 1'b0, tap_wr = 1'b0, commit = 1'b0;
  logic               rnd = 1'b0, sat_clr = 1'b0;
  logic [3:0]         addr = '0;
  logic signed [27:0] t_i = '0, t_q = '0;

  logic signed [11:0] o_i1, o_q1, o_i2, o_q2;
  logic               o_v1, o_v2, o_s1, o_s2;

  always #5 clk = ~clk;

  fse_pipe #(.DECIM(1)) u1 (
    .clk(clk), .i_reset(i_reset), .i_is_data_I(s_i), .i_is_data_Q(s_q),
    .i_is_valid(valid), .i_tap_wr(tap_wr), .i_tap_addr(addr), .i_tap_I(t_i),
    .i_tap_Q(t_q), .i_tap_commit(commit), .i_round(rnd), .i_sat_clr(sat_clr),
    .o_os_data_I(o_i1), .o_os_data_Q(o_q1), .o_os_valid(o_v1), .o_sat(o_s1));

  fse_pipe #(.DECIM(2)) u2 (
    .clk(clk), .i_reset(i_reset), .i_is_data_I(s_i), .i_is_data_Q(s_q),
    .i_is_valid(valid), .i_tap_wr(tap_wr), .i_tap_addr(addr), .i_tap_I(t_i),
    .i_tap_Q(t_q), .i_tap_commit(commit), .i_round(rnd), .i_sat_clr(sat_clr),
    .o_os_data_I(o_i2), .o_os_data_Q(o_q2), .o_os_valid(o_v2), .o_sat(o_s2));

  // ---------------- reference model ----------------
  typedef struct { int due; int ei; int eq; bit es; } exp_t;

  longint sh_i [NT], sh_q [NT], ac_i [NT], ac_q [NT];
  longint hist_i [NT], hist_q [NT];
  exp_t   pq [2][$];
  int     acc_cnt [2];
  bit     sat_m [2], exp_v [2];
  int     last_i [2], last_q [2];
  int     edge_n = 0;

  int n_chk = 0, n_err = 0;

  bit cap_en = 1'b0;
  int cap_i[$], cap_q[$];
  longint lt_i [NT], lt_q [NT];

  task automatic chk(input string nm, input longint act, input longint expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin
      sh_i[k] = 0; sh_q[k] = 0; ac_i[k] = 0; ac_q[k] = 0;
      hist_i[k] = 0; hist_q[k] = 0;
    end
    sh_i[NT/2] = longint'(1) << 25;
    ac_i[NT/2] = longint'(1) << 25;
    for (int d = 0; d < 2; d++) begin
      pq[d].delete();
      acc_cnt[d] = 0; sat_m[d] = 0; exp_v[d] = 0;
      last_i[d] = 0; last_q[d] = 0;
    end
  endtask

  function automatic int qz(input longint y, input bit r, inout bit sat);
    longint t;
    t = y + (r ? (longint'(1) << (D - 1)) : longint'(0));
    t = t >>> D;
    if (t > OMAX) begin sat = 1'b1; return OMAX; end
    if (t < OMIN) begin sat = 1'b1; return OMIN; end
    return int'(t);
  endfunction

  // Called right after each rising edge with the inputs that edge sampled.
  task automatic model_update();
    exp_t x;
    longint yi, yq;
    for (int d = 0; d < 2; d++) begin
      exp_v[d] = 1'b0;
      if (pq[d].size() > 0 && pq[d][0].due == edge_n) begin
        x = pq[d].pop_front();
        exp_v[d] = 1'b1;
        last_i[d] = x.ei;
        last_q[d] = x.eq;
        sat_m[d] = x.es | (sat_m[d] & !sat_clr);
      end else begin
        sat_m[d] = sat_m[d] & !sat_clr;
      end
    end
    if (tap_wr && int'(addr) < NT) begin
      sh_i[addr] = longint'(t_i);
      sh_q[addr] = longint'(t_q);
    end
    if (commit) begin
      for (int k = 0; k < NT; k++) begin
        ac_i[k] = sh_i[k];
        ac_q[k] = sh_q[k];
      end
    end
    if (valid) begin
      for (int k = NT - 1; k > 0; k--) begin
        hist_i[k] = hist_i[k-1];
        hist_q[k] = hist_q[k-1];
      end
      hist_i[0] = longint'(s_i);
      hist_q[0] = longint'(s_q);
      yi = 0; yq = 0;
      for (int k = 0; k < NT; k++) begin
        yi += hist_i[k] * ac_i[k] - hist_q[k] * ac_q[k];
        yq += hist_i[k] * ac_q[k] + hist_q[k] * ac_i[k];
      end
      x.due = edge_n + 3;
      x.es = 1'b0;
      x.ei = qz(yi, rnd, x.es);
      x.eq = qz(yq, rnd, x.es);
      for (int d = 0; d < 2; d++) begin
        if ((acc_cnt[d] % (d + 1)) == d) pq[d].push_back(x);
        acc_cnt[d]++;
      end
    end
  endtask

  task automatic chk_dut(input int d, input logic v, input logic signed [11:0] oi,
                         input logic signed [11:0] oq, input logic s);
    chk($sformatf("dut%0d valid", d), longint'(v), longint'(exp_v[d]));
    chk($sformatf("dut%0d data_I", d), longint'(oi), longint'(last_i[d]));
    chk($sformatf("dut%0d data_Q", d), longint'(oq), longint'(last_q[d]));
    chk($sformatf("dut%0d sat", d), longint'(s), longint'(sat_m[d]));
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_update();
    #1;
    chk_dut(0, o_v1, o_i1, o_q1, o_s1);
    chk_dut(1, o_v2, o_i2, o_q2, o_s2);
    if (cap_en && o_v1) begin
      cap_i.push_back(int'(o_i1));
      cap_q.push_back(int'(o_q1));
    end
  endtask

  task automatic idle();
    valid = 0; tap_wr = 0; commit = 0; sat_clr = 0; s_i = 0; s_q = 0;
  endtask

  // Writes lt_i/lt_q into the shadow bank; commit rides on the last write.
  task automatic load_taps();
    for (int k = 0; k < NT; k++) begin
      tap_wr = 1; addr = 4'(k); t_i = 28'(lt_i[k]); t_q = 28'(lt_q[k]);
      commit = (k == NT - 1);
      tick();
    end
    tap_wr = 0; commit = 0;
  endtask

  task automatic feed_capture(input int xi, input int xq, input int n);
    cap_i.delete(); cap_q.delete();
    cap_en = 1;
    for (int j = 0; j < n + 8; j++) begin
      valid = 1;
      s_i = (j < n) ? 8'(xi) : 8'sd0;
      s_q = (j < n) ? 8'(xq) : 8'sd0;
      tick();
    end
    idle();
    repeat (5) tick();
    cap_en = 0;
  endtask

  task automatic do_reset();
    #2;
    i_reset = 0;
    model_reset();
    #1;
    chk_dut(0, o_v1, o_i1, o_q1, o_s1);
    chk_dut(1, o_v2, o_i2, o_q2, o_s2);
    idle();
    @(negedge clk);
    i_reset = 1;
  endtask

  typedef struct {
    int t3i; int t4i; int t4q; int xi; int xq; int n; bit r; int ei; int eq; bit es;
  } vec_t;

  vec_t vt [9];
  bit   seen;

  initial begin
    vt[0] = '{0,       1 << 25, 0,       64,   0,  1, 1'b0,  256,  0,   1'b0};
    vt[1] = '{0,       0,       1 << 25, 64,   0,  1, 1'b0,  0,    256, 1'b0};
    vt[2] = '{0,       0,       1 << 25, 0,    64, 1, 1'b0, -256,  0,   1'b0};
    vt[3] = '{3 << 25, 3 << 25, 0,       127,  0,  2, 1'b0,  2047, 0,   1'b1};
    vt[4] = '{3 << 25, 3 << 25, 0,      -128,  0,  2, 1'b0, -2048, 0,   1'b1};
    vt[5] = '{0,       1 << 22, 0,       1,    0,  1, 1'b0,  0,    0,   1'b0};
    vt[6] = '{0,       1 << 22, 0,      -1,    0,  1, 1'b0, -1,    0,   1'b0};
    vt[7] = '{0,       1 << 22, 0,       1,    0,  1, 1'b1,  1,    0,   1'b0};
    vt[8] = '{0,       1 << 22, 0,      -1,    0,  1, 1'b1,  0,    0,   1'b0};

    model_reset();
    idle();
    @(negedge clk);
    @(negedge clk);
    chk_dut(0, o_v1, o_i1, o_q1, o_s1);
    chk_dut(1, o_v2, o_i2, o_q2, o_s2);
    i_reset = 1;

    // Latency and decimation phase straight out of reset.
    valid = 1; s_i = 64; s_q = 0;
    tick();
    s_i = 0;
    for (int c = 2; c <= 9; c++) begin
      tick();
      if (c == 3) chk("latency_early", longint'(o_v1), 0);
      if (c == 4) chk("latency_first", longint'(o_v1), 1);
      if (c == 4) chk("decim2_early", longint'(o_v2), 0);
      if (c == 5) chk("decim2_first", longint'(o_v2), 1);
      if (c == 6) chk("decim2_skip", longint'(o_v2), 0);
      if (c == 7) chk("decim2_second", longint'(o_v2), 1);
    end
    idle();
    repeat (5) tick();

    // Directed vectors.
    for (int v = 0; v < 9; v++) begin
      idle();
      repeat (6) tick();
      rnd = vt[v].r;
      sat_clr = 1; tick(); sat_clr = 0;
      for (int k = 0; k < NT; k++) begin lt_i[k] = 0; lt_q[k] = 0; end
      lt_i[3] = vt[v].t3i; lt_i[4] = vt[v].t4i; lt_q[4] = vt[v].t4q;
      load_taps();
      feed_capture(vt[v].xi, vt[v].xq, vt[v].n);
      chk($sformatf("vec%0d count", v), longint'(cap_i.size() >= 5), 1);
      if (cap_i.size() >= 5) begin
        chk($sformatf("vec%0d I", v), cap_i[4], vt[v].ei);
        chk($sformatf("vec%0d Q", v), cap_q[4], vt[v].eq);
      end
      chk($sformatf("vec%0d sat", v), longint'(o_s1), longint'(vt[v].es));
    end

    // Clear coinciding with a new saturation: set must win.
    rnd = 0;
    for (int k = 0; k < NT; k++) begin lt_i[k] = 0; lt_q[k] = 0; end
    lt_i[3] = 3 << 25; lt_i[4] = 3 << 25;
    load_taps();
    seen = 0;
    for (int j = 0; j < 12; j++) begin
      valid = 1; s_i = (j < 2) ? 8'sd127 : 8'sd0; sat_clr = 1;
      tick();
      if (o_s1) seen = 1;
    end
    idle();
    tick();
    chk("satclr_priority", longint'(seen), 1);
    chk("satclr_clears", longint'(o_s1), 0);

    // Shadow writes mid-stream (including out-of-range addresses), then commit.
    for (int j = 0; j < 40; j++) begin
      valid = 1; s_i = 8'($urandom); s_q = 8'($urandom);
      tap_wr = (j >= 4 && j < 20); commit = (j == 28);
      addr = 4'((j - 4) & 15);
      t_i = 28'($urandom) >>> 4; t_q = 28'($urandom) >>> 4;
      tick();
    end
    idle();
    repeat (5) tick();

    // Asynchronous reset in the middle of a saturating stream.
    for (int j = 0; j < 10; j++) begin
      valid = 1; s_i = 8'sd127; tick();
    end
    chk("sat_before_reset", longint'(o_s1), 1);
    do_reset();
    feed_capture(64, 0, 1);
    chk("reset_count", longint'(cap_i.size() >= 5), 1);
    if (cap_i.size() >= 5) chk("reset_identity_I", cap_i[4], 256);

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      if (c % 300 == 0) begin
        idle();
        repeat (5) tick();
        rnd = 1'($urandom);
      end
      valid = ($urandom % 4) != 0;
      s_i = 8'($urandom); s_q = 8'($urandom);
      tap_wr = ($urandom % 6) == 0;
      addr = 4'($urandom);
      t_i = 28'($urandom); t_i = t_i >>> ($urandom % 8);
      t_q = 28'($urandom); t_q = t_q >>> ($urandom % 8);
      commit = ($urandom % 20) == 0;
      sat_clr = ($urandom % 10) == 0;
      tick();
    end
    idle();
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

endmodule
